// File: rtl/wb_slave_regfile_if.sv
// ----------------------------------------------------------------------------
// wb_slave_regfile_if
//   Wishbone B4 bus bundle for the single-master/single-slave register-file
//   link. Signal names are those seen from the slave (responder) side.
//   master modport : drives cyc/stb/we/adr/dat_i/sel/cti/tga, samples dat_o/ack/err
//   slave  modport : the reverse
// ----------------------------------------------------------------------------
interface wb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [2:0]            cti_i;
  logic                  tga_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, tga_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, tga_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_slave_regfile.sv
// ----------------------------------------------------------------------------
// wb_slave_regfile
//   Wishbone B4 slave backed by a DEPTH x DATA_WIDTH register file. Serves
//   classic single cycles and incrementing bursts, terminates out-of-range or
//   illegal accesses with err_o, and exposes a tagged status register
//   {err_cnt, wr_cnt} (saturating halves) when tga_i=1.
// Ports
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : Wishbone slave modport (cyc/stb/we/adr/dat/sel/cti/tga in,
//             dat_o/ack_o/err_o out, all outputs registered)
//   state_o : FSM state for debug (IDLE=0, ACK=1, BURST=2, DONE=3)
// ----------------------------------------------------------------------------
module wb_slave_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  wb_slave_regfile_if.slave    bus,
  output logic [1:0]           state_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int HALF_W    = DATA_WIDTH / 2;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] baddr;
  logic [HALF_W-1:0]     wr_cnt;
  logic [HALF_W-1:0]     err_cnt;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic                  adr_bad;
  logic                  bad_access;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  next_bad;
  logic                  commit_en;
  logic [IDX_W-1:0]      adr_idx;
  logic [IDX_W-1:0]      baddr_idx;
  logic [IDX_W-1:0]      next_idx;

  function automatic logic [HALF_W-1:0] sat_inc(input logic [HALF_W-1:0] v);
    return (&v) ? v : v + HALF_W'(1);
  endfunction

  assign adr_bad    = {1'b0, bus.adr_i} >= DEPTH_L;
  assign bad_access = adr_bad | (bus.tga_i & bus.we_i);
  assign next_addr  = baddr + ADDR_WIDTH'(1);
  assign next_bad   = {1'b0, next_addr} >= DEPTH_L;
  assign adr_idx    = bus.adr_i[IDX_W-1:0];
  assign baddr_idx  = baddr[IDX_W-1:0];
  assign next_idx   = next_addr[IDX_W-1:0];

  // A write beat commits on the edge where the master still requests and sees
  // a normal ack. baddr holds the beat address in both ACK and BURST, and an
  // error termination never carries ack_q, so it can never write.
  assign commit_en = bus.cyc_i & bus.stb_i & bus.we_i & ~bus.tga_i & ack_q &
                     ((state == ACK) || (state == BURST));

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      baddr   <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      // NOTE: the register file is architecturally cleared on reset, so the
      // array is reset word by word here rather than left uninitialised.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (commit_en) begin
        for (int b = 0; b < SEL_WIDTH; b++) begin
          if (bus.sel_i[b]) mem[baddr_idx][b*8 +: 8] <= bus.dat_i[b*8 +: 8];
        end
        wr_cnt <= sat_inc(wr_cnt);
      end

      if (!bus.cyc_i) begin
        // Cycle abort wins over everything else on the bus.
        state <= IDLE;
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.stb_i) begin
              baddr <= bus.adr_i;
              if (bad_access) begin
                err_q   <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                state   <= ACK;
              end else begin
                ack_q <= 1'b1;
                if (!bus.we_i) dat_q <= bus.tga_i ? {err_cnt, wr_cnt} : mem[adr_idx];
                state <= (bus.cti_i == CTI_INCR && !bus.tga_i) ? BURST : ACK;
              end
            end
          end

          ACK: begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= DONE;
          end

          DONE: begin
            // Wait for the master to release stb so a held strobe is not
            // mistaken for a second request.
            if (!bus.stb_i) state <= IDLE;
          end

          BURST: begin
            if (!bus.stb_i) begin
              ack_q <= 1'b0;
            end else if (!ack_q) begin
              // Resume after a master wait state.
              ack_q <= 1'b1;
              dat_q <= mem[baddr_idx];
            end else if (bus.cti_i == CTI_END) begin
              ack_q <= 1'b0;
              state <= DONE;
            end else begin
              baddr <= next_addr;
              if (next_bad) begin
                ack_q   <= 1'b0;
                err_q   <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                state   <= ACK;
              end else begin
                dat_q <= mem[next_idx];
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.dat_o = dat_q;
  assign state_o   = state;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_slave_regfile
//   Self-checking bench for wb_slave_regfile. Classic accesses come from a
//   vector table; bursts, held strobes and mid-burst reset are hand sequences.
//   Every request pushes its expected termination onto a scoreboard queue that
//   a negedge monitor pops whenever ack_o or err_o is seen.
// ----------------------------------------------------------------------------
module tb_wb_slave_regfile;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] state_o;

  always #5 clk_i = ~clk_i;

  wb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .bus     (bus),
    .state_o (state_o)
  );

  int checks = 0;
  int errors = 0;
  int exp_wr  = 0;
  int exp_err = 0;

  typedef struct {
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        tga;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic is_err, input logic chk, input logic [31:0] d);
    exp_t e;
    e.exp_err = is_err;
    e.chk_dat = chk;
    e.dat     = d;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every termination must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && (bus.ack_o === 1'b1 || bus.err_o === 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_response", {30'b0, bus.ack_o, bus.err_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_kind", {30'b0, bus.ack_o, bus.err_o}, mon_e.exp_err ? 32'd1 : 32'd2);
        if (mon_e.chk_dat) check("rdata", bus.dat_o, mon_e.dat);
      end
    end
  end

  task automatic bus_idle();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.sel_i = '0;
    bus.cti_i = 3'b000;
    bus.tga_i = 1'b0;
  endtask

  // Classic single cycle, entered and left on a falling edge. The strobe is
  // held 'hold' cycles after the termination is first seen.
  task automatic classic(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic tga, input logic is_err,
                         input logic [31:0] exp_dat, input int hold);
    bit seen;
    seen = 1'b0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = dat;
    bus.sel_i = sel;
    bus.cti_i = 3'b000;
    bus.tga_i = tga;
    expect_resp(is_err, !we && !is_err, exp_dat);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_i);
      if (bus.ack_o === 1'b1 || bus.err_o === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      check("response_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) sb.delete(0);
    end
    repeat (hold) @(negedge clk_i);
    bus_idle();
    @(negedge clk_i);
    if (we && !is_err) exp_wr++;
    if (is_err) exp_err++;
  endtask

  task automatic status_read(input logic [31:0] exp_dat);
    classic(1'b0, 5'd2, 32'd0, 4'h0, 1'b1, 1'b0, exp_dat, 1);
  endtask

  logic [31:0] bexp[4];
  int n_ack;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    adr    dat           sel   tga   err   exp_dat
    vecs[0]  = '{1'b1, 5'd0,  32'h0000_1111, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b0, 1'b0, 32'h0000_1111};
    vecs[2]  = '{1'b1, 5'd20, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b0, 1'b0, 32'h0000_1111};
    vecs[4]  = '{1'b1, 5'd1,  32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd2,  32'h0,         4'h0, 1'b1, 1'b0, 32'h0001_0002};
    vecs[6]  = '{1'b1, 5'd3,  32'h1111_1111, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 5'd3,  32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd3,  32'h0,         4'h0, 1'b0, 1'b0, 32'h11BB_11DD};
    vecs[9]  = '{1'b1, 5'd0,  32'h5555_5555, 4'hF, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 5'd16, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 5'd15, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0003_0004};
    vecs[12] = '{1'b0, 5'd16, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 5'd1,  32'h0,         4'h0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[14] = '{1'b1, 5'd4,  32'hA000_0004, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 5'd5,  32'hB000_0005, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 5'd6,  32'hC000_0006, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 5'd7,  32'hD000_0007, 4'hF, 1'b0, 1'b0, 32'h0};
    bexp[0] = 32'hA000_0004;
    bexp[1] = 32'hB000_0005;
    bexp[2] = 32'hC000_0006;
    bexp[3] = 32'hD000_0007;

    // Reset state.
    bus_idle();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_ack", {31'b0, bus.ack_o}, 32'd0);
    check("reset_err", {31'b0, bus.err_o}, 32'd0);
    check("reset_dat", bus.dat_o, 32'd0);
    check("reset_state", {30'b0, state_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Classic accesses from the table.
    for (int i = 0; i < 18; i++) begin
      classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].tga,
              vecs[i].exp_err, vecs[i].exp_dat, 1);
    end

    // Incrementing burst read of mem[4..7], last beat tagged end-of-burst.
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 5'd4;
    bus.cti_i = 3'b010;
    for (int k = 0; k < 4; k++) expect_resp(1'b0, 1'b1, bexp[k]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("burst_rd_ack", {31'b0, bus.ack_o}, 32'd1);
      if (k >= 1) begin
        bus.adr_i = 5'(4 + k);
        bus.cti_i = (k == 3) ? 3'b111 : 3'b010;
      end
    end
    @(negedge clk_i);
    check("burst_rd_end_ack", {31'b0, bus.ack_o}, 32'd0);
    check("burst_rd_done_state", {30'b0, state_o}, 32'd3);
    bus_idle();
    @(negedge clk_i);
    check("burst_rd_idle_state", {30'b0, state_o}, 32'd0);

    // Burst write from 14 runs off the end of the file after two beats.
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 5'd14;
    bus.dat_i = 32'hE000_000E;
    bus.sel_i = 4'hF;
    bus.cti_i = 3'b010;
    expect_resp(1'b0, 1'b0, 32'd0);
    expect_resp(1'b0, 1'b0, 32'd0);
    expect_resp(1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    check("burst_wr_beat1", {30'b0, bus.ack_o, bus.err_o}, 32'd2);
    @(negedge clk_i);
    check("burst_wr_beat2", {30'b0, bus.ack_o, bus.err_o}, 32'd2);
    bus.adr_i = 5'd15;
    bus.dat_i = 32'hF000_000F;
    @(negedge clk_i);
    check("burst_wr_overrun", {30'b0, bus.ack_o, bus.err_o}, 32'd1);
    bus.adr_i = 5'd16;
    bus.dat_i = 32'h9999_9999;
    @(negedge clk_i);
    check("burst_wr_err_drop", {30'b0, bus.ack_o, bus.err_o}, 32'd0);
    bus_idle();
    @(negedge clk_i);
    exp_wr  += 2;
    exp_err += 1;
    classic(1'b0, 5'd14, 32'd0, 4'h0, 1'b0, 1'b0, 32'hE000_000E, 1);
    classic(1'b0, 5'd15, 32'd0, 4'h0, 1'b0, 1'b0, 32'hF000_000F, 1);
    classic(1'b0, 5'd0,  32'd0, 4'h0, 1'b0, 1'b0, 32'h0000_1111, 1);
    status_read({16'(exp_err), 16'(exp_wr)});

    // Classic write with the strobe held three extra cycles: one ack, one commit.
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 5'd2;
    bus.dat_i = 32'h2222_2222;
    bus.sel_i = 4'hF;
    bus.cti_i = 3'b000;
    expect_resp(1'b0, 1'b0, 32'd0);
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (bus.ack_o === 1'b1) n_ack++;
    end
    check("held_stb_ack_pulses", 32'(n_ack), 32'd1);
    check("held_stb_done_state", {30'b0, state_o}, 32'd3);
    bus_idle();
    @(negedge clk_i);
    check("held_stb_idle_state", {30'b0, state_o}, 32'd0);
    exp_wr++;
    classic(1'b0, 5'd2, 32'd0, 4'h0, 1'b0, 1'b0, 32'h2222_2222, 1);
    status_read({16'(exp_err), 16'(exp_wr)});

    // Reset asserted in the middle of a burst.
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 5'd8;
    bus.cti_i = 3'b010;
    expect_resp(1'b0, 1'b1, 32'd0);
    expect_resp(1'b0, 1'b1, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midburst_rst_ack", {31'b0, bus.ack_o}, 32'd0);
    check("midburst_rst_state", {30'b0, state_o}, 32'd0);
    check("midburst_rst_dat", bus.dat_o, 32'd0);
    @(negedge clk_i);
    bus_idle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    exp_wr  = 0;
    exp_err = 0;
    classic(1'b0, 5'd14, 32'd0, 4'h0, 1'b0, 1'b0, 32'h0, 1);
    status_read({16'(exp_err), 16'(exp_wr)});

    repeat (2) @(negedge clk_i);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
